// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared definitions for the LFSR controller slice.
//   LFSR_W    - shift register width (4)
//   STEPS_W   - width of the step-count request (4, value 0 means 16)
//   LFSR_TAPS - tap mask for x^4+x^3+1 (bits 3 and 2 feed back)
//   state_t   - controller FSM states
//   lfsr_next - one left shift with the XOR of the tapped bits entering at bit 0
package lfsr_pkg;

   localparam int LFSR_W  = 4;
   localparam int STEPS_W = 4;
   localparam int CNT_W   = STEPS_W + 1;

   localparam logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/lfsr_ctrl_if.sv
// lfsr_ctrl_if: request/result bundle of the LFSR controller.
//   start/seed/steps        - request, driven by the master
//   busy                    - controller is in LOAD, RUN or DONE
//   out_valid/out_data      - freshly shifted LFSR value
//   done                    - one-cycle pulse when a run completes
//   err_zero                - one-cycle pulse when a start carries seed 0
//   period_hit              - out_data equals the captured seed (only with out_valid)
//   state                   - debug view of the controller FSM
//
// Handshake: a request is taken when start=1 is sampled on a rising edge while
// the controller is IDLE (busy=0). Nothing is queued: a start seen while busy
// is dropped, and a start held high is taken on the first IDLE edge.
interface lfsr_ctrl_if;
   import lfsr_pkg::*;

   logic                start;
   logic [LFSR_W-1:0]   seed;
   logic [STEPS_W-1:0]  steps;
   logic                busy;
   logic                out_valid;
   logic [LFSR_W-1:0]   out_data;
   logic                done;
   logic                err_zero;
   logic                period_hit;
   state_t              state;

   modport master (
      output start, seed, steps,
      input  busy, out_valid, out_data, done, err_zero, period_hit, state
   );

   modport slave (
      input  start, seed, steps,
      output busy, out_valid, out_data, done, err_zero, period_hit, state
   );

endinterface

// File: rtl/lfsr4_core.sv
// lfsr4_core: 4-bit Fibonacci LFSR register, polynomial x^4+x^3+1.
//   clk   - clock, rising edge
//   reset - synchronous, active low; clears q
//   load  - q <= din (has priority over shift)
//   shift - q <= lfsr_next(q)
//   din   - value for load
//   q     - register contents
module lfsr4_core
   import lfsr_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [LFSR_W-1:0] din,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/lfsr_ctrl.sv
// lfsr_ctrl: runs the 4-bit LFSR for a requested number of shifts.
//   clk   - clock, rising edge
//   reset - synchronous, active low
//   bus   - lfsr_ctrl_if.slave (request in, results/status out)
// A run is IDLE -> LOAD (seed into LFSR, counter set) -> RUN (one shift per
// cycle) -> DONE -> IDLE. out_valid, period_hit, done and err_zero are
// registered, so each appears in the cycle after the edge that caused it.
module lfsr_ctrl
   import lfsr_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   lfsr_ctrl_if.slave bus
);

   state_t              state;
   state_t              state_nxt;
   logic [LFSR_W-1:0]   seed_cap;
   logic [STEPS_W-1:0]  steps_cap;
   logic [CNT_W-1:0]    cnt;
   logic [LFSR_W-1:0]   q;

   logic                capture;
   logic                load;
   logic                shift;
   logic                valid_nxt;
   logic                hit_nxt;
   logic                done_nxt;
   logic                err_nxt;

   logic                valid_r;
   logic                hit_r;
   logic                done_r;
   logic                err_r;

   lfsr4_core u_core (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .din   (seed_cap),
      .q     (q)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      valid_nxt = 1'b0;
      hit_nxt   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.seed == '0) begin
                  err_nxt = 1'b1;
               end else begin
                  capture   = 1'b1;
                  state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            load      = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            shift     = 1'b1;
            valid_nxt = 1'b1;
            // Compare the value about to be registered, so the flag lines up
            // with the out_data it describes.
            hit_nxt   = (lfsr_next(q) == seed_cap);
            if (cnt == CNT_W'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         seed_cap  <= '0;
         steps_cap <= '0;
         cnt       <= '0;
         valid_r   <= 1'b0;
         hit_r     <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         if (capture) begin
            seed_cap  <= bus.seed;
            steps_cap <= bus.steps;
         end
         // A step request of 0 means a full 16 shifts, hence the extra bit.
         if (load) begin
            cnt <= (steps_cap == '0) ? CNT_W'(16) : {1'b0, steps_cap};
         end else if (shift) begin
            cnt <= cnt - CNT_W'(1);
         end
         valid_r <= valid_nxt;
         hit_r   <= hit_nxt;
         done_r  <= done_nxt;
         err_r   <= err_nxt;
      end
   end

   assign bus.busy       = (state != IDLE);
   assign bus.out_valid  = valid_r;
   assign bus.out_data   = q;
   assign bus.period_hit = hit_r;
   assign bus.done       = done_r;
   assign bus.err_zero   = err_r;
   assign bus.state      = state;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// tb_lfsr_ctrl: self-checking bench for lfsr_ctrl.
module tb_lfsr_ctrl;
   import lfsr_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   lfsr_ctrl_if bus ();

   lfsr_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- scoreboard ----------------
   logic [3:0] exp_q[$];
   logic       exp_hit_q[$];

   function automatic logic [3:0] model_next(input logic [3:0] v);
      return {v[2:0], v[3] ^ v[2]};
   endfunction

   task automatic push_run(input logic [3:0] s, input logic [3:0] st);
      logic [3:0] v;
      int n;
      v = s;
      n = (st == 4'd0) ? 16 : int'(st);
      for (int i = 0; i < n; i++) begin
         v = model_next(v);
         exp_q.push_back(v);
         exp_hit_q.push_back(v == s);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] ed;
      logic       eh;
      if (bus.out_valid === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected_valid: got data %b, expected no output", bus.out_data);
         end else begin
            ed = exp_q.pop_front();
            eh = exp_hit_q.pop_front();
            if (bus.out_data !== ed || bus.period_hit !== eh) begin
               n_fail++;
               $display("FAIL sb_data: got %b hit %b, expected %b hit %b",
                        bus.out_data, bus.period_hit, ed, eh);
            end
         end
      end else begin
         n_checks++;
         if (bus.period_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_hit_no_valid: got period_hit %b, expected 0", bus.period_hit);
         end
      end
   end

   // ---------------- driver tasks ----------------
   logic [3:0] obs_data[$];
   int obs_valid, obs_first, obs_done, obs_done_k, obs_hit, obs_hit_k;

   task automatic drive_start(input logic [3:0] s, input logic [3:0] st);
      @(negedge clk);
      bus.start = 1'b1;
      bus.seed  = s;
      bus.steps = st;
      if (s != 4'd0) push_run(s, st);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic observe_run(input int n_cycles);
      obs_data.delete();
      obs_valid = 0; obs_first = -1; obs_done = 0; obs_done_k = -1;
      obs_hit = 0; obs_hit_k = -1;
      for (int k = 1; k <= n_cycles; k++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            obs_valid++;
            obs_data.push_back(bus.out_data);
            if (obs_first < 0) obs_first = k;
         end
         if (bus.done === 1'b1) begin
            obs_done++;
            obs_done_k = k;
         end
         if (bus.period_hit === 1'b1) begin
            obs_hit++;
            obs_hit_k = k;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 ||
          bus.err_zero !== 1'b0 || bus.period_hit !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got busy %b valid %b done %b err %b hit %b, expected all 0",
                  bus.busy, bus.out_valid, bus.done, bus.err_zero, bus.period_hit);
      end
      n_checks++;
      if (bus.out_data !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_data: got %b expected 0000", bus.out_data);
      end
      n_checks++;
      if (bus.state !== IDLE) begin
         n_fail++;
         $display("FAIL reset_state: got %0d expected IDLE", bus.state);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] tbl [4];
      tbl[0] = 4'b1110; tbl[1] = 4'b1100; tbl[2] = 4'b1000; tbl[3] = 4'b0001;
      drive_start(4'b1111, 4'd4);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.state !== LOAD) begin
         n_fail++;
         $display("FAIL basic_load: got busy %b state %0d, expected 1 LOAD", bus.busy, bus.state);
      end
      observe_run(8);
      n_checks++;
      if (obs_valid != 4 || obs_first != 2) begin
         n_fail++;
         $display("FAIL basic_valid: got %0d valids first at %0d, expected 4 at 2", obs_valid, obs_first);
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_data[i] !== tbl[i]) begin
               n_fail++;
               $display("FAIL basic_data[%0d]: got %b expected %b", i, obs_data[i], tbl[i]);
            end
         end
      end
      n_checks++;
      if (obs_done != 1 || obs_done_k != 6) begin
         n_fail++;
         $display("FAIL basic_done: got %0d pulses last at %0d, expected 1 at 6", obs_done, obs_done_k);
      end
      n_checks++;
      if (obs_hit != 0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_hit_busy: got hits %0d busy %b, expected 0 0", obs_hit, bus.busy);
      end
   endtask

   task automatic test_period();
      drive_start(4'b1111, 4'd15);
      observe_run(20);
      n_checks++;
      if (obs_valid != 15) begin
         n_fail++;
         $display("FAIL period_count: got %0d expected 15", obs_valid);
      end else begin
         n_checks++;
         if (obs_data[14] !== 4'b1111) begin
            n_fail++;
            $display("FAIL period_last: got %b expected 1111", obs_data[14]);
         end
      end
      n_checks++;
      if (obs_hit != 1 || obs_hit_k != 16 || obs_done_k != 17) begin
         n_fail++;
         $display("FAIL period_hit: got %0d hits at %0d done at %0d, expected 1 at 16 done 17",
                  obs_hit, obs_hit_k, obs_done_k);
      end
   endtask

   task automatic test_zero_seed();
      // The previous run left 1111 in the LFSR.
      @(negedge clk);
      bus.start = 1'b1;
      bus.seed  = 4'b0000;
      bus.steps = 4'd5;
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if (bus.err_zero !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_pulse: got err %b busy %b, expected 1 0", bus.err_zero, bus.busy);
      end
      @(negedge clk);
      n_checks++;
      if (bus.err_zero !== 1'b0 || bus.busy !== 1'b0 || bus.out_data !== 4'b1111) begin
         n_fail++;
         $display("FAIL zero_after: got err %b busy %b data %b, expected 0 0 1111",
                  bus.err_zero, bus.busy, bus.out_data);
      end
   endtask

   task automatic test_steps_zero();
      drive_start(4'b0001, 4'd0);
      observe_run(20);
      n_checks++;
      if (obs_valid != 16) begin
         n_fail++;
         $display("FAIL steps0_count: got %0d expected 16", obs_valid);
      end else begin
         n_checks++;
         if (obs_data[14] !== 4'b0001 || obs_data[15] !== 4'b0010) begin
            n_fail++;
            $display("FAIL steps0_tail: got %b %b expected 0001 0010", obs_data[14], obs_data[15]);
         end
      end
      n_checks++;
      if (obs_hit != 1 || obs_hit_k != 16 || obs_done_k != 18) begin
         n_fail++;
         $display("FAIL steps0_hit: got %0d hits at %0d done at %0d, expected 1 at 16 done 18",
                  obs_hit, obs_hit_k, obs_done_k);
      end
   endtask

   task automatic test_reset_abort();
      drive_start(4'b0011, 4'd8);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0 ||
          bus.err_zero !== 1'b0 || bus.period_hit !== 1'b0 || bus.out_data !== 4'b0000) begin
         n_fail++;
         $display("FAIL abort_outputs: got busy %b valid %b done %b err %b hit %b data %b, expected all 0",
                  bus.busy, bus.out_valid, bus.done, bus.err_zero, bus.period_hit, bus.out_data);
      end
      n_checks++;
      if (exp_q.size() != 6) begin
         n_fail++;
         $display("FAIL abort_consumed: got %0d pending, expected 6", exp_q.size());
      end
      exp_q.delete();
      exp_hit_q.delete();
      reset = 1'b1;
      observe_run(4);
      n_checks++;
      if (obs_done != 0 || obs_valid != 0) begin
         n_fail++;
         $display("FAIL abort_no_done: got done %0d valid %0d, expected 0 0", obs_done, obs_valid);
      end
      drive_start(4'b1000, 4'd1);
      observe_run(4);
      n_checks++;
      if (obs_valid != 1 || obs_done_k != 3) begin
         n_fail++;
         $display("FAIL abort_restart: got %0d valids done at %0d, expected 1 at 3", obs_valid, obs_done_k);
      end else begin
         n_checks++;
         if (obs_data[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_restart_data: got %b expected 0001", obs_data[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [12:0] vmask, dmask, bmask;
      vmask = '0; dmask = '0; bmask = '0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.seed  = 4'b0101;
      bus.steps = 4'd3;
      push_run(4'b0101, 4'd3);
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         vmask[k] = (bus.out_valid === 1'b1);
         dmask[k] = (bus.done === 1'b1);
         bmask[k] = (bus.busy === 1'b1);
         if (k == 1) begin
            bus.start = 1'b1;
            bus.seed  = 4'b1001;
            bus.steps = 4'd2;
         end
         if (k == 2) bus.start = 1'b0;
         if (k == 3) begin
            bus.start = 1'b1;
            bus.seed  = 4'b1010;
            bus.steps = 4'd2;
            push_run(4'b1010, 4'd2);
         end
         if (k == 6) bus.start = 1'b0;
      end
      n_checks++;
      if (vmask !== 13'h31C) begin
         n_fail++;
         $display("FAIL b2b_valid: got %b expected %b", vmask, 13'h31C);
      end
      n_checks++;
      if (dmask !== 13'h420) begin
         n_fail++;
         $display("FAIL b2b_done: got %b expected %b", dmask, 13'h420);
      end
      n_checks++;
      if (bmask !== 13'h3DE) begin
         n_fail++;
         $display("FAIL b2b_busy: got %b expected %b", bmask, 13'h3DE);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      bus.start = 1'b0;
      bus.seed  = 4'd0;
      bus.steps = 4'd0;
      test_reset();
      test_basic();
      test_period();
      test_zero_seed();
      test_steps_zero();
      test_reset_abort();
      test_back_to_back();
      repeat (2) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no completion, expected finish before 50000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 4 bits and the polynomial at x^4+x^3+1.
REQ-002 The block SHALL have port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `reset`, input, 1 bit: synchronous, active-low reset, sampled on rising `clk`.
REQ-004 The block SHALL have port `start`, input, 1 bit: request a run; sampled only in IDLE.
REQ-005 The block SHALL have port `seed`, input, 4 bits: initial LFSR value, captured with `start`.
REQ-006 The block SHALL have port `steps`, input, 4 bits: number of shifts, captured with `start`; 0 encodes 16.
REQ-007 The block SHALL have port `busy`, output, 1 bit: high in LOAD, RUN and DONE.
REQ-008 The block SHALL have port `out_valid`, output, 1 bit: `out_data` holds a freshly shifted value this cycle.
REQ-009 The block SHALL have port `out_data`, output, 4 bits: current LFSR register contents.
REQ-010 The block SHALL have port `done`, output, 1 bit: single-cycle pulse at end of run.
REQ-011 The block SHALL have port `err_zero`, output, 1 bit: single-cycle pulse when `start` is given with `seed`==0000.
REQ-012 The block SHALL have port `period_hit`, output, 1 bit: high with `out_valid` when `out_data` equals the captured seed.

Function
REQ-013 The shift SHALL be next = {q[2:0], q[3]^q[2]}, giving a maximal period of 15 for any nonzero seed.
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, RUN and DONE.
REQ-015 In IDLE, when `start`=1 and `seed`!=0 at edge N, the block SHALL capture `seed` and `steps` and enter LOAD after edge N.
REQ-016 In LOAD, at edge N+1 the block SHALL load the LFSR with the captured seed, initialise the remaining counter to `steps` (0 treated as 16, using a 5-bit counter) and enter RUN.
REQ-017 In RUN, the block SHALL shift once per cycle and decrement the counter; `out_valid` SHALL be high after edges N+2 through N+1+S, where S is the step count.
REQ-018 On the shift at which the counter reaches 0, the block SHALL enter DONE; `done` SHALL be high for the single cycle after edge N+2+S, and the block SHALL return to IDLE at the next edge.
REQ-019 In IDLE, when `start`=1 and `seed`==0000, the block SHALL pulse `err_zero` for one cycle, remain in IDLE and leave the LFSR unchanged.
REQ-020 `start` SHALL be ignored in LOAD, RUN and DONE, with no queuing.
REQ-021 `out_data` SHALL hold its last value in IDLE and DONE.
REQ-022 `period_hit` SHALL be 0 whenever `out_valid`=0.
REQ-023 A `start` in the same cycle as DONE SHALL be ignored; a `start` held high SHALL be accepted in the IDLE cycle after DONE.

Reset
REQ-024 When `reset`=0 at a rising edge, the block SHALL take state IDLE, LFSR=0000, counter=0, captured seed=0000, and drive `busy`/`out_valid`/`done`/`err_zero`/`period_hit`=0 and `out_data`=0000.
REQ-025 Reset SHALL override all activity, including a run in progress, and no `done` SHALL be produced for the aborted run.
REQ-026 After reset, the first accepted `start` SHALL behave identically to a start from power-up.

Structure
REQ-027 Shared package `lfsr_pkg` SHALL hold the FSM state enum, LFSR width (4) and the tap constant.
REQ-028 The 4-bit shift register SHALL be a sub-module `lfsr4_core` (ports: `clk`, `reset`, `load`, `shift`, `din`, `q`); lfsr_ctrl SHALL contain the FSM and counter only.

Verification
REQ-029 Seed 1111 with steps=4: `out_data` SHALL read 1110, 1100, 1000, 0001 on 4 valid cycles; `done` SHALL pulse once; `period_hit`=0.
REQ-030 Seed 1111 with steps=15: the 15th valid value SHALL be 1111 with `period_hit`=1 on that cycle only.
REQ-031 Seed 0000 with `start`: `err_zero` SHALL pulse one cycle; `busy`=0 throughout; `out_data` SHALL be unchanged.
REQ-032 Steps=0 with seed 0001: exactly 16 valid cycles SHALL occur; the 15th value SHALL be 0001 with `period_hit`=1; the 16th SHALL be 0010.
REQ-033 Reset asserted on the 3rd RUN cycle: all outputs SHALL be 0 on the next cycle, with no `done`; a new start with seed 1000 and steps=1 SHALL produce 0001.
REQ-034 `start` pulsed during RUN and held high through DONE: the current run SHALL be unaffected, and the new run SHALL be accepted in the IDLE cycle after DONE.
